divider: RTL and testbench



---
 rtl/divider_if.sv | 25 ++
 rtl/divider.sv | 109 ++++++++++
 tb/tb_divider.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Start/done handshake bundle for the sequential restoring divider.
// The requester drives start/P/B; the divider answers with Q/R/busy/done/dbz.
// Handshake: start is sampled only when the divider is idle or showing done.
// done pulses for one cycle exactly when Q/R/dbz take new values.
interface divider_if;
    logic       start;
    logic [5:0] P;
    logic [2:0] B;
    logic [5:0] Q;
    logic [2:0] R;
    logic       busy;
    logic       done;
    logic       dbz;
    logic [1:0] state;

    modport master (
        output start, P, B,
        input  Q, R, busy, done, dbz, state
    );

    modport slave (
        input  start, P, B,
        output Q, R, busy, done, dbz, state
    );
endinterface

// File: rtl/divider.sv
// Sequential restoring divider, 6-bit dividend by 3-bit divisor.
// Retires one quotient bit per clock; results held until the next completion.
module divider (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave io
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [5:0] dividend;
    logic [2:0] divisor;
    logic [3:0] rem;
    logic [5:0] quo;
    logic [2:0] cnt;

    logic [5:0] q_reg;
    logic [2:0] r_reg;
    logic       dbz_reg;

    logic       accept;
    logic       last_iter;
    logic [3:0] trial;
    logic       ge;
    logic [3:0] rem_nxt;
    logic [5:0] quo_nxt;

    assign accept    = io.start && (state == IDLE || state == DONE);
    assign last_iter = (state == RUN) && (cnt == 3'd5);

    // One restoring step: the partial remainder stays below 14, so 4 bits suffice.
    always_comb begin
        trial   = {rem[2:0], dividend[5]};
        ge      = (trial >= {1'b0, divisor});
        rem_nxt = ge ? (trial - {1'b0, divisor}) : trial;
        quo_nxt = {quo[4:0], ge};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.start) state_nxt = RUN;
            RUN:     if (cnt == 3'd5) state_nxt = DONE;
            DONE:    state_nxt = io.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dividend <= 6'd0;
            divisor  <= 3'd0;
            rem      <= 4'd0;
            quo      <= 6'd0;
            cnt      <= 3'd0;
        end else if (accept) begin
            dividend <= io.P;
            divisor  <= io.B;
            rem      <= 4'd0;
            quo      <= 6'd0;
            cnt      <= 3'd0;
        end else if (state == RUN) begin
            dividend <= {dividend[4:0], 1'b0};
            rem      <= rem_nxt;
            quo      <= quo_nxt;
            cnt      <= last_iter ? 3'd0 : cnt + 3'd1;
        end
    end

    // Results move only on the completion edge; a zero divisor forces the all-ones quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg   <= 6'd0;
            r_reg   <= 3'd0;
            dbz_reg <= 1'b0;
        end else if (last_iter) begin
            if (divisor == 3'd0) begin
                q_reg   <= 6'h3F;
                r_reg   <= 3'd0;
                dbz_reg <= 1'b1;
            end else begin
                q_reg   <= quo_nxt;
                r_reg   <= rem_nxt[2:0];
                dbz_reg <= 1'b0;
            end
        end
    end

    assign io.Q     = q_reg;
    assign io.R     = r_reg;
    assign io.dbz   = dbz_reg;
    assign io.busy  = (state == RUN);
    assign io.done  = (state == DONE);
    assign io.state = state;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the restoring divider: expected results are queued
// at stimulus time and popped when done is seen.
module tb_divider;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;

    logic [9:0] exp_q[$];

    divider_if io();

    divider dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] model(input logic [5:0] p, input logic [2:0] b);
        logic [5:0] q;
        logic [2:0] r;
        if (b == 3'd0) return {1'b1, 6'h3F, 3'd0};
        q = p / b;
        r = 3'(p % b);
        return {1'b0, q, r};
    endfunction

    // Drives one request and waits for done; returns observed values only.
    task automatic do_op(input logic [5:0] p, input logic [2:0] b,
                         output logic [9:0] obs, output int lat,
                         output int busy_cnt, output int done_cyc);
        @(negedge clk);
        io.start = 1'b1;
        io.P     = p;
        io.B     = b;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        io.P     = 6'($urandom);
        io.B     = 3'($urandom);
        busy_cnt = io.busy ? 1 : 0;
        lat      = -1;
        done_cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (io.done) begin
                lat      = i;
                done_cyc = cyc;
                break;
            end
            if (io.busy) busy_cnt++;
        end
        obs = {io.dbz, io.Q, io.R};
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        io.start = 1'b1;
        io.P     = 6'd42;
        io.B     = 3'd6;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({io.busy, io.done, io.dbz, io.Q, io.R} !== 12'd0) begin
                fails++;
                $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b Q=%0d R=%0d, want all 0",
                         io.busy, io.done, io.dbz, io.Q, io.R);
            end
        end
        @(negedge clk);
        io.start = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [5:0] p, input logic [2:0] b,
                                 input bit check_lat);
        logic [9:0] obs;
        logic [9:0] e;
        int lat, bc, dc;
        exp_q.push_back(model(p, b));
        do_op(p, b, obs, lat, bc, dc);
        e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL %s P=%0d B=%0d: got dbz=%b Q=%0d R=%0d, want dbz=%b Q=%0d R=%0d",
                     name, p, b, obs[9], obs[8:3], obs[2:0], e[9], e[8:3], e[2:0]);
        end
        if (check_lat) begin
            tests++;
            if (lat !== 6 || bc !== 6 || io.busy !== 1'b0) begin
                fails++;
                $display("FAIL %s_timing: got latency=%0d busy_cycles=%0d busy_at_done=%b, want 6 6 0",
                         name, lat, bc, io.busy);
            end
        end
    endtask

    task automatic test_basic();
        run_and_check("basic_42_6", 6'd42, 3'd6, 1'b1);
        run_and_check("basic_63_5", 6'd63, 3'd5, 1'b1);
        run_and_check("basic_0_7", 6'd0, 3'd7, 1'b1);
    endtask

    task automatic test_sweep();
        logic [9:0] obs;
        logic [9:0] e;
        int lat, bc, dc;
        int bad_inv, bad_full;
        bad_inv  = 0;
        bad_full = 0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 1; b < 8; b++) begin
                exp_q.push_back({1'b0, 6'(a), 3'd0});
                do_op(6'(a * b), 3'(b), obs, lat, bc, dc);
                e = exp_q.pop_front();
                if (obs !== e || lat !== 6) bad_inv++;
            end
        end
        tests++;
        if (bad_inv != 0) begin
            fails++;
            $display("FAIL mult_inverse: got %0d bad products, want 0", bad_inv);
        end
        for (int p = 0; p < 64; p++) begin
            for (int b = 1; b < 8; b++) begin
                exp_q.push_back(model(6'(p), 3'(b)));
                do_op(6'(p), 3'(b), obs, lat, bc, dc);
                e = exp_q.pop_front();
                if (obs !== e || (int'(obs[8:3]) * b + int'(obs[2:0])) != p ||
                    int'(obs[2:0]) >= b || lat !== 6)
                    bad_full++;
            end
        end
        tests++;
        if (bad_full != 0) begin
            fails++;
            $display("FAIL full_sweep: got %0d bad pairs, want 0", bad_full);
        end
    endtask

    task automatic test_dbz();
        run_and_check("dbz_5_0", 6'd5, 3'd0, 1'b1);
        run_and_check("after_dbz_9_4", 6'd9, 3'd4, 1'b0);
    endtask

    task automatic test_ignored_start();
        int done_seen, first_done;
        logic [9:0] obs;
        logic [9:0] e;
        exp_q.push_back(model(6'd50, 3'd3));
        @(negedge clk);
        io.start = 1'b1;
        io.P     = 6'd50;
        io.B     = 3'd3;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        io.start = 1'b1;
        io.P     = 6'd7;
        io.B     = 3'd7;
        @(posedge clk);
        #1;
        io.start   = 1'b0;
        done_seen  = 0;
        first_done = -1;
        obs        = '0;
        for (int i = 3; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (io.done) begin
                done_seen++;
                if (first_done < 0) begin
                    first_done = i;
                    obs = {io.dbz, io.Q, io.R};
                end
            end
        end
        e = exp_q.pop_front();
        tests++;
        if (done_seen !== 1 || first_done !== 6 || obs !== e) begin
            fails++;
            $display("FAIL ignored_start: got dones=%0d at=%0d Q=%0d R=%0d, want 1 at 6 Q=%0d R=%0d",
                     done_seen, first_done, obs[8:3], obs[2:0], e[8:3], e[2:0]);
        end
    endtask

    task automatic test_back_to_back();
        int done_seen;
        logic [9:0] obs1, obs2;
        logic [9:0] e;
        int lat1, lat2, bc, dc1, dc2;
        @(negedge clk);
        io.start = 1'b1;
        io.P     = 6'd61;
        io.B     = 3'd2;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (io.done) done_seen++;
        end
        tests++;
        if (done_seen !== 0 || {io.busy, io.dbz, io.Q, io.R} !== 11'd0) begin
            fails++;
            $display("FAIL reset_mid_run: got dones=%0d busy=%b dbz=%b Q=%0d R=%0d, want 0 0 0 0 0",
                     done_seen, io.busy, io.dbz, io.Q, io.R);
        end
        exp_q.push_back(model(6'd33, 3'd4));
        exp_q.push_back(model(6'd20, 3'd3));
        do_op(6'd33, 3'd4, obs1, lat1, bc, dc1);
        do_op(6'd20, 3'd3, obs2, lat2, bc, dc2);
        e = exp_q.pop_front();
        tests++;
        if (obs1 !== e || lat1 !== 6) begin
            fails++;
            $display("FAIL b2b_first: got Q=%0d R=%0d lat=%0d, want Q=%0d R=%0d lat=6",
                     obs1[8:3], obs1[2:0], lat1, e[8:3], e[2:0]);
        end
        e = exp_q.pop_front();
        tests++;
        if (obs2 !== e || dc2 - dc1 !== 7) begin
            fails++;
            $display("FAIL b2b_second: got Q=%0d R=%0d spacing=%0d, want Q=%0d R=%0d spacing=7",
                     obs2[8:3], obs2[2:0], dc2 - dc1, e[8:3], e[2:0]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (io.done !== 1'b0) begin
            fails++;
            $display("FAIL done_single_cycle: got done=%b, want 0", io.done);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        rst      = 1'b0;
        io.start = 1'b0;
        io.P     = 6'd0;
        io.B     = 3'd0;
        test_reset();
        test_basic();
        test_sweep();
        test_dbz();
        test_ignored_start();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
